// File: rtl/sgdmac_apb_pkg.sv
// Shared APB definitions for the SGDMAC control path.
// Holds the requester FSM state type, the APB bus widths and the configuration
// register offsets used by both the APB requester and the config slave.
package sgdmac_apb_pkg;

    localparam int unsigned APB_ADDR_W = 12;
    localparam int unsigned APB_DATA_W = 32;

    // Configuration register map.
    localparam logic [APB_ADDR_W-1:0] ADDR_VERSION  = 12'h000;
    localparam logic [APB_ADDR_W-1:0] ADDR_DESC_PTR = 12'h100;
    localparam logic [APB_ADDR_W-1:0] ADDR_CTRL     = 12'h104;
    localparam logic [APB_ADDR_W-1:0] ADDR_STATUS   = 12'h108;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_t;

endpackage

// File: rtl/sgdmac_apb_master.sv
// Single-outstanding APB requester.
// Turns a valid/ready command (write/read, address, data) into an APB
// SETUP/ACCESS sequence and returns read data, slave error and timeout status
// on a valid/ready response channel.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_*                     command channel (valid/ready, write, addr, wdata)
//   rsp_*                     response channel (valid/ready, rdata, slverr, timeout)
//   psel_o .. pwdata_o        APB request outputs
//   pready_i, prdata_i, pslverr_i  APB completer inputs
// Every output is a register or a decode of the FSM state; no input reaches an
// output combinationally.
module sgdmac_apb_master
    import sgdmac_apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_slverr_o,
    output logic              rsp_timeout_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic              pwrite_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic              pready_i,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pslverr_i
);

    // Counter value seen in the last permitted ACCESS cycle.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

    apb_mst_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              slverr_q, slverr_d;
    logic              timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        slverr_d  = slverr_q;
        timeout_d = timeout_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    write_d = cmd_write_i;
                    wdata_d = cmd_wdata_i;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    // A completion in the abort cycle still counts as a normal transfer.
                    slverr_d  = pslverr_i;
                    rdata_d   = (!write_q && !pslverr_i) ? prdata_i : '0;
                    timeout_d = 1'b0;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntLast)) begin
                        slverr_d  = 1'b1;
                        rdata_d   = '0;
                        timeout_d = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            slverr_q  <= slverr_d;
            timeout_q <= timeout_d;
        end
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign psel_o        = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o     = (state_q == ACCESS);
    assign rsp_valid_o   = (state_q == RESP);
    assign paddr_o       = addr_q;
    assign pwrite_o      = write_q;
    assign pwdata_o      = wdata_q;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_slverr_o  = slverr_q;
    assign rsp_timeout_o = timeout_q;

endmodule

// File: tb/tb_sgdmac_apb_master.sv
// Directed bench for sgdmac_apb_master with TIMEOUT_CYCLES=4.
module tb_sgdmac_apb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [11:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_slverr_o, rsp_timeout_o;
    logic        psel_o, penable_o, pwrite_o;
    logic [11:0] paddr_o;
    logic [31:0] pwdata_o;
    logic        pready_i;
    logic [31:0] prdata_i;
    logic        pslverr_i;

    int errors = 0;
    int checks = 0;

    // Slave register file, word indexed.
    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    sgdmac_apb_master #(
        .ADDR_W         (12),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4),
        .CNT_W          (9)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_write_i   (cmd_write_i),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_wdata_i   (cmd_wdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_slverr_o  (rsp_slverr_o),
        .rsp_timeout_o (rsp_timeout_o),
        .psel_o        (psel_o),
        .penable_o     (penable_o),
        .paddr_o       (paddr_o),
        .pwrite_o      (pwrite_o),
        .pwdata_o      (pwdata_o),
        .pready_i      (pready_i),
        .prdata_i      (prdata_i),
        .pslverr_i     (pslverr_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer: n_access ACCESS cycles; pready_i rises in the last one when
    // ready_ok, otherwise it stays low (timeout). bp = response backpressure cycles.
    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                        input int n_access, input logic ready_ok, input logic serr,
                        input int bp, input logic [31:0] exp_rdata, input logic exp_serr,
                        input logic exp_to);
        logic last;
        check("idle_cmd_ready", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        step();
        // Scramble the command bus to prove the request was latched.
        cmd_valid_i = 1'b0;
        cmd_addr_i  = ~addr;
        cmd_wdata_i = ~wdata;
        cmd_write_i = ~wr;
        check("setup_psel", psel_o, 1);
        check("setup_penable", penable_o, 0);
        check("setup_cmd_ready", cmd_ready_o, 0);
        for (int i = 0; i < n_access; i++) begin
            step();
            last      = ready_ok && (i == n_access - 1);
            pready_i  = last;
            pslverr_i = serr;
            prdata_i  = wr ? 32'hFFFF_FFFF : mem[addr[11:2]];
            if (last && wr && !serr) mem[addr[11:2]] = wdata;
            check("access_psel", psel_o, 1);
            check("access_penable", penable_o, 1);
            check("access_paddr", paddr_o, addr);
            check("access_pwrite", pwrite_o, wr);
            if (wr) check("access_pwdata", pwdata_o, wdata);
            check("access_rsp_valid", rsp_valid_o, 0);
            check("access_cmd_ready", cmd_ready_o, 0);
        end
        step();
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        prdata_i  = 32'h1234_5678;
        check("resp_valid", rsp_valid_o, 1);
        check("resp_psel", psel_o, 0);
        check("resp_penable", penable_o, 0);
        check("resp_rdata", rsp_rdata_o, exp_rdata);
        check("resp_slverr", rsp_slverr_o, exp_serr);
        check("resp_timeout", rsp_timeout_o, exp_to);
        rsp_ready_i = 1'b0;
        for (int j = 0; j < bp; j++) begin
            step();
            check("bp_valid", rsp_valid_o, 1);
            check("bp_rdata", rsp_rdata_o, exp_rdata);
            check("bp_slverr", rsp_slverr_o, exp_serr);
            check("bp_timeout", rsp_timeout_o, exp_to);
            check("bp_cmd_ready", cmd_ready_o, 0);
        end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        check("done_rsp_valid", rsp_valid_o, 0);
        check("done_cmd_ready", cmd_ready_o, 1);
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
        mem[0]            = 32'h0101_2024;
        mem[12'h104 >> 2] = 32'h5555_AAAA;
        mem[12'h108 >> 2] = 32'h6666_9999;
        rst         = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_wdata_i = '0;
        rsp_ready_i = 1'b0;
        pready_i    = 1'b0;
        prdata_i    = '0;
        pslverr_i   = 1'b0;
        step();
        step();
        rst = 1'b0;

        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_psel", psel_o, 0);
        check("rst_penable", penable_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_paddr", paddr_o, 0);
        check("rst_pwdata", pwdata_o, 0);
        check("rst_rdata", rsp_rdata_o, 0);
        check("rst_slverr", rsp_slverr_o, 0);
        check("rst_timeout", rsp_timeout_o, 0);

        // Zero-wait write, then reads.
        xfer(1'b1, 12'h100, 32'hDEAD_BEEF, 1, 1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        xfer(1'b0, 12'h000, 32'h0, 1, 1'b1, 1'b0, 0, 32'h0101_2024, 1'b0, 1'b0);
        xfer(1'b0, 12'h100, 32'h0, 1, 1'b1, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        // Three wait states; ready lands exactly in the would-be abort cycle.
        xfer(1'b1, 12'h104, 32'h0000_00A5, 4, 1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        // Slave error on read with 5 cycles of response backpressure.
        xfer(1'b0, 12'h104, 32'h0, 1, 1'b1, 1'b1, 5, 32'h0, 1'b1, 1'b0);
        // Timeout: pready stuck low for 4 ACCESS cycles.
        xfer(1'b0, 12'h108, 32'h0, 4, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b1);
        // Command after timeout is handled normally.
        xfer(1'b0, 12'h000, 32'h0, 1, 1'b1, 1'b0, 0, 32'h0101_2024, 1'b0, 1'b0);

        // Reset during ACCESS discards the transfer.
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b1;
        cmd_addr_i  = 12'h104;
        cmd_wdata_i = 32'h0000_0077;
        step();
        cmd_valid_i = 1'b0;
        step();
        check("mid_access_penable", penable_o, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_psel", psel_o, 0);
        check("mid_rst_penable", penable_o, 0);
        check("mid_rst_rsp_valid", rsp_valid_o, 0);
        check("mid_rst_cmd_ready", cmd_ready_o, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_rst_rsp_valid", rsp_valid_o, 0);
            check("post_rst_psel", psel_o, 0);
        end
        xfer(1'b0, 12'h100, 32'h0, 2, 1'b1, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sgdmac_apb_master.md
Name: sgdmac_apb_master

Overview:
- Single-outstanding APB requester (completer side is the SGDMAC configuration slave and other 12-bit-address APB peripherals).
- Converts a valid/ready command channel (write or read, address, data) into a compliant APB SETUP/ACCESS sequence.
- Returns read data, slave error and timeout status on a valid/ready response channel.
- Used by the SoC control bridge and by bench drivers to program descriptor pointer / control and poll status.

Parameters:
ADDR_W, 12, APB address width
DATA_W, 32, APB data width
TIMEOUT_CYCLES, 256, max ACCESS cycles waiting for pready_i; 0 disables timeout
CNT_W, 9, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
cmd_valid_i  input  1  command present
cmd_ready_o  output  1  command accepted when valid&ready
cmd_write_i  input  1  1 = write, 0 = read
cmd_addr_i  input  ADDR_W  target address
cmd_wdata_i  input  DATA_W  write data
rsp_valid_o  output  1  response present
rsp_ready_i  input  1  response consumed when valid&ready
rsp_rdata_o  output  DATA_W  read data; 0 for writes, errors and timeouts
rsp_slverr_o  output  1  pslverr_i sampled at completion, or forced 1 on timeout
rsp_timeout_o  output  1  transfer aborted by timeout
psel_o  output  1  APB select
penable_o  output  1  APB enable
paddr_o  output  ADDR_W  APB address
pwrite_o  output  1  APB direction
pwdata_o  output  DATA_W  APB write data
pready_i  input  1  APB ready
prdata_i  input  DATA_W  APB read data
pslverr_i  input  1  APB slave error

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - FSM goes to IDLE.
  - All outputs go to 0, except cmd_ready_o=1.
  - Timeout counter = 0.
- FSM states IDLE, SETUP, ACCESS, RESP. All outputs are registered or decoded from state only; no combinational input-to-output paths.
- IDLE:
  - cmd_ready_o=1; psel_o=0, penable_o=0.
  - On cmd_valid_i: latch write/addr/wdata into paddr_o/pwrite_o/pwdata_o and go to SETUP.
- SETUP (one cycle): psel_o=1, penable_o=0, cmd_ready_o=0. Always goes to ACCESS; counter cleared.
- ACCESS: psel_o=1, penable_o=1; paddr_o, pwrite_o and pwdata_o are held stable for the whole transfer.
  - pready_i=1:
    - Capture pslverr_i.
    - Capture prdata_i only if the transfer is a read and pslverr_i=0; otherwise rdata=0.
    - Go to RESP.
  - pready_i=0: increment counter. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 in the same cycle, abort:
    - rsp_timeout=1, rsp_slverr=1, rdata=0; go to RESP.
  - pready_i arriving in the abort cycle wins: normal completion, no timeout.
- RESP:
  - psel_o=0, penable_o=0, rsp_valid_o=1; response fields held stable until rsp_ready_i.
  - On rsp_ready_i: go to IDLE; rsp_valid_o drops next cycle.
- Latency, zero-wait slave, rsp_ready_i tied 1:
  - Cycle T: command accepted.
  - T+1: SETUP.
  - T+2: ACCESS, completes.
  - T+3: rsp_valid_o.
  - T+4: IDLE, cmd_ready_o=1.
  - Peak throughput: one transfer per 4 cycles. Each wait state adds 1 cycle.
- paddr_o, pwrite_o and pwdata_o keep their last values while idle. No requirement on them when psel_o=0.
- Reset mid-transfer (SETUP, ACCESS or RESP):
  - psel_o, penable_o and rsp_valid_o are 0 after that edge.
  - The in-flight command and its response are discarded.
- Exactly one transfer outstanding; cmd_ready_o is never 1 outside IDLE.

Decomposition:
- Package sgdmac_apb_pkg holds:
  - state enum apb_mst_state_t {IDLE, SETUP, ACCESS, RESP};
  - APB_ADDR_W=12 and APB_DATA_W=32;
  - register offset constants 0x000 version, 0x100 descriptor pointer, 0x104 control, 0x108 status, shared with the config slave.
- Single module; the timeout counter stays inline. No sub-module is warranted.

Test Plan:
- Write, zero-wait slave: write 0x100 = 0xDEAD_BEEF.
  - APB: SETUP at T+1, ACCESS at T+2 with paddr=0x100, pwdata=0xDEADBEEF.
  - Response at T+3: slverr=0, timeout=0, rdata=0.
- Read, zero-wait slave: read 0x000 from a slave model returning 0x0101_2024.
  - rsp_rdata_o=0x01012024 at T+3.
  - A following read of 0x100 returns 0xDEADBEEF.
- Wait states: slave holds pready_i=0 for 3 ACCESS cycles.
  - psel, penable, paddr and pwdata stay stable for all 4 ACCESS cycles.
  - Response at T+6.
- Slave error: read 0x104 with pslverr_i=1 at completion -> rsp_slverr_o=1, rsp_rdata_o=0, rsp_timeout_o=0.
- Timeout with TIMEOUT_CYCLES=4, pready_i stuck 0:
  - Abort after 4 ACCESS cycles; rsp_timeout_o=1, rsp_slverr_o=1.
  - psel_o drops; the next command is accepted normally.
- Backpressure and reset:
  - rsp_ready_i low for 5 cycles -> response stable and cmd_ready_o=0 throughout.
  - rst pulsed during ACCESS -> next cycle psel_o=0, rsp_valid_o=0, cmd_ready_o=1; no response is emitted.
